// File: rtl/event_grant_mux.sv
// rtl/event_grant_mux.sv - moves the arbiter-granted core's event packet into a small output FIFO
module event_grant_mux #(
    parameter int NR    = 4,
    parameter int SW    = 2,
    parameter int DW    = 64,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NR-1:0]    req,
    input  logic [NR*DW-1:0] req_data,
    input  logic [SW-1:0]    egnt,
    input  logic             eval,
    output logic [NR-1:0]    ack,
    output logic             full,
    output logic             out_vld,
    output logic [DW-1:0]    out_data,
    output logic [SW-1:0]    out_src,
    input  logic             out_rdy,
    output logic             err
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [DW-1:0] data_q [DEPTH];
    logic [SW-1:0] src_q  [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          err_q, err_d;

    logic          req_sel;
    logic [DW-1:0] wr_data;
    logic          accept;
    logic          pop;

    always_comb begin
        req_sel = 1'b0;
        wr_data = '0;
        for (int i = 0; i < NR; i++) begin
            if (egnt == SW'(i)) begin
                req_sel = req[i];
                wr_data = req_data[i*DW +: DW];
            end
        end
    end

    // full reflects the count at the start of the cycle, so a same-cycle pop never frees a slot
    assign full    = (count_q == CW'(DEPTH));
    assign out_vld = (count_q != '0);
    assign accept  = eval & req_sel & ~full;
    assign pop     = out_vld & out_rdy;
    assign ack     = accept ? (NR'(1) << egnt) : '0;

    assign out_data = data_q[rd_ptr_q];
    assign out_src  = src_q[rd_ptr_q];
    assign err      = err_q;

    always_comb begin
        wr_ptr_d = accept ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({accept, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        err_d = err_q | (eval & ~req_sel);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            err_q    <= err_d;
        end
    end

    // storage is cleared on reset so out_data/out_src read as zero when empty after reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
                src_q[i]  <= '0;
            end
        end else if (accept) begin
            data_q[wr_ptr_q] <= wr_data;
            src_q[wr_ptr_q]  <= egnt;
        end
    end

endmodule
